conv_window_scan_ctrl: RTL
==========================

# conv_window_scan_ctrl

Sequencer that walks a K×K convolution window across an input feature map of configurable width and height. It emits one (row, col) window origin per valid/ready transfer to the convolution datapath. It sits between the layer control registers and the window-fetch/MAC datapath, replacing ad-hoc chained free-running counters with a single handshaked scan engine. Each scan starts on a start pulse and ends with a one-cycle done pulse.

## Interface
- BITWIDTH, 10, width of image dimensions and of the row/col outputs
- KBITS, 4, width of the kernel-size input

- SCAN_Clk  input  1  clock; all state updates on the rising edge
- COUNTER_Clr  input  1  reset, asynchronous, active-low
- SCAN_Start  input  1  start request; sampled only in IDLE
- SCAN_Abort  input  1  synchronous abort; returns to IDLE without a done pulse
- SCAN_ImgW  input  BITWIDTH  image width in pixels; sampled with Start
- SCAN_ImgH  input  BITWIDTH  image height in pixels; sampled with Start
- SCAN_K  input  KBITS  kernel size K; sampled with Start
- SCAN_Ready  input  1  datapath accepts the current window
- SCAN_Valid  output  1  SCAN_Row/SCAN_Col hold a window origin to be consumed
- SCAN_Row  output  BITWIDTH  window top row
- SCAN_Col  output  BITWIDTH  window left column
- SCAN_Last  output  1  current window is the final one of the scan (qualified by Valid)
- SCAN_Busy  output  1  high in LOAD and RUN
- SCAN_Done  output  1  one-cycle pulse at scan completion
- SCAN_Err  output  1  one-cycle pulse coincident with Done when the configuration is illegal

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: on Start=1, register ImgW, ImgH and K, then go to LOAD. While not in IDLE, Start is ignored.
- LOAD:
  - Compute colMax = ImgW−K and rowMax = ImgH−K into registers, at BITWIDTH+1 bits to detect sign.
  - Illegal configuration is K=0, K>ImgW or K>ImgH. On illegal configuration go to DONE with the error flag set, and emit no windows.
  - Otherwise clear row and col and go to RUN.
- RUN:
  - Valid=1 continuously. A transfer occurs on a rising edge with Valid=1 and Ready=1.
  - Without a transfer, Row, Col and Last are held stable. Valid must not drop before the transfer.
  - On a transfer with col<colMax: col+1.
  - On a transfer with col==colMax and row<rowMax: col←0, row+1.
  - On a transfer with col==colMax and row==rowMax (Last=1): go to DONE.
- Last = (col==colMax) && (row==rowMax), combinational from registers.
- DONE: Done=1 for exactly one cycle, Err=1 in the same cycle if the configuration was illegal, then go to IDLE.
- Abort=1 in LOAD, RUN or DONE: next state is IDLE, Valid drops, and no Done pulse is generated. A transfer in the abort cycle still counts at the datapath. Abort in IDLE has no effect, and Abort overrides Start.
- Total transfers per scan = (ImgW−K+1)·(ImgH−K+1). Raster order is row-major, col fastest.
- Arithmetic is unsigned. Row/col never exceed rowMax/colMax, so no wrap-around occurs.

## Timing
- Reset: on COUNTER_Clr=0, immediately force state=IDLE and row=col=0. Valid, Last, Busy, Done and Err are all 0, as are Row and Col. This applies in any state and mid-scan. Scan resumes only on a new Start after release.
- Start latency:
  - Start sampled at edge n.
  - LOAD during cycle n+1.
  - First Valid with (0,0) visible after edge n+2.
- Back-to-back throughput: one window per cycle while Ready=1.
- Done is asserted in the cycle after the final transfer edge.
- The earliest next Start is accepted in the cycle after Done, i.e. in IDLE.
- Illegal configuration: Start at edge n, LOAD in cycle n+1, Done=Err=1 in cycle n+2, IDLE in cycle n+3.
- Outputs are registered or derived only from registers; there is no combinational path from Ready to Valid, Row or Col.

## Test plan
- Basic 4×4, K=3, Ready tied 1:
  - Exactly 4 transfers: (0,0), (0,1), (1,0), (1,1).
  - Last only on (1,1).
  - Done pulse 1 cycle later; Busy high from LOAD through the final RUN cycle.
- Backpressure with ImgW=5, ImgH=3, K=3:
  - Ready toggled pseudo-randomly.
  - Valid stays high and outputs stay stable while Ready=0.
  - Sequence (0,0), (0,1), (0,2), then Done, with no duplicates or skips.
- Boundaries:
  - K=ImgW=ImgH=3 gives a single transfer (0,0) with Last=1 on it.
  - K=1 on 2×2 gives 4 transfers.
  - ImgW=ImgH=1023, K=1 gives 1023² transfers ending at (1022,1022) with no overflow.
- Illegal configurations:
  - K=0, and separately K=5 with ImgW=4: Valid never asserted, Done=Err=1 in the same cycle at n+2.
  - A subsequent legal Start works normally.
- Abort and Start interaction:
  - Abort at window (0,1) of a 4×4, K=2 scan: IDLE next cycle, no Done.
  - Start pulses during RUN are ignored; the next Start restarts at (0,0).
- Reset mid-scan:
  - Assert COUNTER_Clr=0 asynchronously between clock edges during RUN: all outputs go to 0 immediately.
  - After release, the block stays idle until Start.

Source files
------------

// File: rtl/conv_window_scan_ctrl_if.sv
// conv_window_scan_ctrl_if: window-origin stream from the scan engine to the convolution datapath.
interface conv_window_scan_ctrl_if #(parameter int BITWIDTH = 10);
    logic                SCAN_Valid;
    logic                SCAN_Ready;
    logic                SCAN_Last;
    logic [BITWIDTH-1:0] SCAN_Row;
    logic [BITWIDTH-1:0] SCAN_Col;
    modport master(output SCAN_Valid, SCAN_Row, SCAN_Col, SCAN_Last, input SCAN_Ready);
    modport slave(input SCAN_Valid, SCAN_Row, SCAN_Col, SCAN_Last, output SCAN_Ready);
endinterface

// File: rtl/conv_window_scan_ctrl.sv
// conv_window_scan_ctrl: handshaked raster scan of KxK window origins over a feature map.
module conv_window_scan_ctrl #(
    parameter int BITWIDTH = 10,
    parameter int KBITS    = 4
) (
    input  logic                   SCAN_Clk,
    input  logic                   COUNTER_Clr,
    input  logic                   SCAN_Start,
    input  logic                   SCAN_Abort,
    input  logic [BITWIDTH-1:0]    SCAN_ImgW,
    input  logic [BITWIDTH-1:0]    SCAN_ImgH,
    input  logic [KBITS-1:0]       SCAN_K,
    output logic                   SCAN_Busy,
    output logic                   SCAN_Done,
    output logic                   SCAN_Err,
    conv_window_scan_ctrl_if.master win
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    logic [1:0]          r_state;
    logic [BITWIDTH-1:0] r_imgw, r_imgh, r_row, r_col;
    logic [KBITS-1:0]    r_k;
    logic [BITWIDTH:0]   r_colmax, r_rowmax;
    logic                r_err;
    logic [BITWIDTH:0]   w_colmax, w_rowmax;
    logic                w_bad, w_col_end, w_row_end;
    // The extra MSB of the max values is the borrow, flagging K larger than the image.
    assign w_colmax  = {1'b0, r_imgw} - {{(BITWIDTH+1-KBITS){1'b0}}, r_k};
    assign w_rowmax  = {1'b0, r_imgh} - {{(BITWIDTH+1-KBITS){1'b0}}, r_k};
    assign w_bad     = (r_k == '0) || w_colmax[BITWIDTH] || w_rowmax[BITWIDTH];
    assign w_col_end = {1'b0, r_col} == r_colmax;
    assign w_row_end = {1'b0, r_row} == r_rowmax;
    assign win.SCAN_Valid = r_state == S_RUN;
    assign win.SCAN_Row   = r_row;
    assign win.SCAN_Col   = r_col;
    assign win.SCAN_Last  = (r_state == S_RUN) && w_col_end && w_row_end;
    assign SCAN_Busy = (r_state == S_LOAD) || (r_state == S_RUN);
    assign SCAN_Done = (r_state == S_DONE) && !SCAN_Abort;
    assign SCAN_Err  = SCAN_Done && r_err;
    always_ff @(posedge SCAN_Clk or negedge COUNTER_Clr) begin
        if (!COUNTER_Clr) begin
            r_state  <= S_IDLE;
            r_imgw   <= '0;
            r_imgh   <= '0;
            r_k      <= '0;
            r_colmax <= '0;
            r_rowmax <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_err    <= 1'b0;
        end else if (SCAN_Abort && r_state != S_IDLE) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (SCAN_Start) begin
                    r_imgw  <= SCAN_ImgW;
                    r_imgh  <= SCAN_ImgH;
                    r_k     <= SCAN_K;
                    r_err   <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_colmax <= w_colmax;
                    r_rowmax <= w_rowmax;
                    r_row    <= '0;
                    r_col    <= '0;
                    r_err    <= w_bad;
                    r_state  <= w_bad ? S_DONE : S_RUN;
                end
                S_RUN: if (win.SCAN_Ready) begin
                    if (!w_col_end) r_col <= r_col + 1'b1;
                    else if (!w_row_end) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
